// File: rtl/fmap_pad_sched_pkg.sv
// Shared encodings for the feature scratch-pad read sequencer.
package fmap_pad_sched_pkg;
    localparam logic [2:0] ST_IDLE       = 3'b000;
    localparam logic [2:0] ST_START_FULL = 3'b001;
    localparam logic [2:0] ST_READ       = 3'b010;
    localparam logic [2:0] ST_WAIT_LOAD  = 3'b011;
    localparam logic [2:0] ST_START_COL  = 3'b100;
    localparam logic [2:0] ST_DONE       = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_START_FULL = ST_START_FULL,
        S_READ       = ST_READ,
        S_WAIT_LOAD  = ST_WAIT_LOAD,
        S_START_COL  = ST_START_COL,
        S_DONE       = ST_DONE
    } state_t;

    localparam logic LOAD_FULL = 1'b1;
    localparam logic LOAD_COL  = 1'b0;
endpackage

// File: rtl/fmap_pad_sched_rd_addr_gen.sv
// Pad read address generator: idx/pass counters, base+idx address and the
// read-data strobes delayed to line up with the pad RAM output.
module fmap_pad_sched_rd_addr_gen #(
    parameter int AW_F = 8,
    parameter int AW_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            issue,
    input  logic [AW_F-1:0] base,
    input  logic [AW_F-1:0] pixel_num,
    input  logic [AW_W-1:0] weight_num,
    output logic [AW_F-1:0] raddr,
    output logic            win_end,
    output logic            addr_pending,
    output logic            rd_valid,
    output logic            rd_pass_last,
    output logic            rd_win_last
);
    logic [AW_F-1:0] idx;
    logic [AW_W-1:0] pass;
    logic            idx_last;
    logic            pass_final;
    logic            pass_last_q;
    logic            win_last_q;

    assign idx_last   = (idx == pixel_num - AW_F'(1));
    assign pass_final = (pass == weight_num - AW_W'(1));
    assign win_end    = idx_last && pass_final;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            pass         <= '0;
            raddr        <= '0;
            addr_pending <= 1'b0;
            pass_last_q  <= 1'b0;
            win_last_q   <= 1'b0;
            rd_valid     <= 1'b0;
            rd_pass_last <= 1'b0;
            rd_win_last  <= 1'b0;
        end else begin
            // stage 1: address cycle, stage 2: data cycle
            addr_pending <= issue;
            pass_last_q  <= issue && idx_last;
            win_last_q   <= issue && win_end;
            rd_valid     <= addr_pending;
            rd_pass_last <= pass_last_q;
            rd_win_last  <= win_last_q;
            if (issue) begin
                raddr <= base + idx;
            end
            if (clr) begin
                idx  <= '0;
                pass <= '0;
            end else if (issue) begin
                if (idx_last) begin
                    idx  <= '0;
                    pass <= pass_final ? '0 : pass + AW_W'(1);
                end else begin
                    idx <= idx + AW_F'(1);
                end
            end
        end
    end
endmodule

// File: rtl/fmap_pad_sched.sv
// Feature scratch-pad load/read sequencer for one PE: one full-window load,
// then a column load per later window, weight_num read sweeps per window.
//  state      | meaning
//  IDLE       | wait for layer_start, latch config
//  START_FULL | pulse full-window load request
//  READ       | sweep pad addresses, stalled by ready/full
//  WAIT_LOAD  | wait for outstanding load, advance window base
//  START_COL  | pulse single-column load request
//  DONE       | drain read pipeline, pulse layer_done
module fmap_pad_sched
    import fmap_pad_sched_pkg::*;
#(
    parameter int ADDRESSWIDTH_F_PAD = 8,
    parameter int ADDRESSWIDTH_W_PAD = 8,
    parameter int WIN_CNT_WIDTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          layer_start,
    input  logic [WIN_CNT_WIDTH-1:0]      num_windows,
    input  logic [ADDRESSWIDTH_W_PAD-1:0] weight_num,
    input  logic [ADDRESSWIDTH_F_PAD-1:0] pixel_num,
    input  logic [ADDRESSWIDTH_F_PAD-1:0] col_len,
    input  logic                          pad_data_ready,
    input  logic                          pad_full,
    input  logic                          fmap_ready_to_pe,
    output logic                          fmap_load_start,
    output logic                          load_full_cloumn,
    output logic [ADDRESSWIDTH_F_PAD-1:0] raddra_ifmap,
    output logic                          fmap_rd_valid,
    output logic                          pass_last,
    output logic                          window_done,
    output logic                          layer_done,
    output logic                          busy
);
    state_t                        state;
    logic [WIN_CNT_WIDTH-1:0]      nw_q;
    logic [WIN_CNT_WIDTH-1:0]      win;
    logic [ADDRESSWIDTH_W_PAD-1:0] wn_q;
    logic [ADDRESSWIDTH_F_PAD-1:0] pn_q;
    logic [ADDRESSWIDTH_F_PAD-1:0] col_q;
    logic [ADDRESSWIDTH_F_PAD-1:0] base;
    logic                          load_pending;
    logic                          issue;
    logic                          clr;
    logic                          win_end;
    logic                          addr_pending;

    // pad_full is checked combinationally so a same-cycle rise blocks the issue
    assign issue = (state == S_READ) && pad_data_ready && !pad_full;
    assign clr   = (state == S_IDLE) || (state == S_WAIT_LOAD);

    fmap_pad_sched_rd_addr_gen #(
        .AW_F(ADDRESSWIDTH_F_PAD),
        .AW_W(ADDRESSWIDTH_W_PAD)
    ) u_rd_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .issue       (issue),
        .base        (base),
        .pixel_num   (pn_q),
        .weight_num  (wn_q),
        .raddr       (raddra_ifmap),
        .win_end     (win_end),
        .addr_pending(addr_pending),
        .rd_valid    (fmap_rd_valid),
        .rd_pass_last(pass_last),
        .rd_win_last (window_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_pending <= 1'b0;
        end else if (fmap_load_start) begin
            load_pending <= 1'b1;
        end else if (fmap_ready_to_pe) begin
            load_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_IDLE;
            nw_q             <= '0;
            wn_q             <= '0;
            pn_q             <= '0;
            col_q            <= '0;
            base             <= '0;
            win              <= '0;
            fmap_load_start  <= 1'b0;
            load_full_cloumn <= 1'b0;
            layer_done       <= 1'b0;
            busy             <= 1'b0;
        end else begin
            fmap_load_start  <= 1'b0;
            load_full_cloumn <= LOAD_COL;
            layer_done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (layer_start) begin
                        nw_q  <= num_windows;
                        wn_q  <= weight_num;
                        pn_q  <= pixel_num;
                        col_q <= col_len;
                        base  <= '0;
                        win   <= '0;
                        busy  <= 1'b1;
                        if ((num_windows == '0) || (weight_num == '0) || (pixel_num == '0)) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_START_FULL;
                        end
                    end
                end
                S_START_FULL: begin
                    // a load left pending by the previous layer must finish first
                    if (!load_pending) begin
                        fmap_load_start  <= 1'b1;
                        load_full_cloumn <= LOAD_FULL;
                        state            <= S_READ;
                    end
                end
                S_READ: begin
                    if (issue && win_end) begin
                        state <= (win < nw_q - WIN_CNT_WIDTH'(1)) ? S_WAIT_LOAD : S_DONE;
                    end
                end
                S_WAIT_LOAD: begin
                    if (!load_pending) begin
                        base  <= base + col_q;
                        win   <= win + WIN_CNT_WIDTH'(1);
                        state <= S_START_COL;
                    end
                end
                S_START_COL: begin
                    if (!load_pending) begin
                        fmap_load_start  <= 1'b1;
                        load_full_cloumn <= LOAD_COL;
                        state            <= S_READ;
                    end
                end
                S_DONE: begin
                    // hold layer_done until the final read has left the pipeline
                    if (!addr_pending) begin
                        layer_done <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fmap_pad_sched.sv
// Directed bench for fmap_pad_sched: full load, column loads, stall, wrap,
// degenerate config, busy-ignore and mid-layer reset.
module tb_fmap_pad_sched;
    localparam int MAXC = 120;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       layer_start = 1'b0;
    logic [7:0] num_windows = '0;
    logic [7:0] weight_num = '0;
    logic [7:0] pixel_num = '0;
    logic [7:0] col_len = '0;
    logic       pad_data_ready = 1'b0;
    logic       pad_full = 1'b0;
    logic       fmap_ready_to_pe = 1'b0;
    logic       fmap_load_start;
    logic       load_full_cloumn;
    logic [7:0] raddra_ifmap;
    logic       fmap_rd_valid;
    logic       pass_last;
    logic       window_done;
    logic       layer_done;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] got_addr[$];
    logic [7:0] exp_addr[$];
    bit         got_plast[$];
    bit         exp_plast[$];
    int         rd_cyc[$];
    int         wdone_cyc[$];
    int         start_cyc[$];
    int         ready_cyc[$];
    bit         start_full[$];
    int         ldone_cyc;
    int         ldone_cnt;
    int         viol;
    bit         timed_out;
    logic [7:0] hist_addr[0:MAXC];
    bit         hist_busy[0:MAXC];

    fmap_pad_sched dut (
        .clk             (clk),
        .rst             (rst),
        .layer_start     (layer_start),
        .num_windows     (num_windows),
        .weight_num      (weight_num),
        .pixel_num       (pixel_num),
        .col_len         (col_len),
        .pad_data_ready  (pad_data_ready),
        .pad_full        (pad_full),
        .fmap_ready_to_pe(fmap_ready_to_pe),
        .fmap_load_start (fmap_load_start),
        .load_full_cloumn(load_full_cloumn),
        .raddra_ifmap    (raddra_ifmap),
        .fmap_rd_valid   (fmap_rd_valid),
        .pass_last       (pass_last),
        .window_done     (window_done),
        .layer_done      (layer_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Drives one layer from a sample point (#1 after an edge); cycle 0 carries layer_start.
    task automatic run_layer(input int nw, input int wn, input int pn, input int col,
                             input int stall_at, input int stall_len, input int ready_dly,
                             input int extra_start);
        int ready_at;
        bit pend;
        bit rdy;
        got_addr.delete(); got_plast.delete(); rd_cyc.delete(); wdone_cyc.delete();
        start_cyc.delete(); ready_cyc.delete(); start_full.delete();
        ldone_cyc = -1; ldone_cnt = 0; viol = 0; timed_out = 1'b1;
        ready_at = -1; pend = 1'b0;
        num_windows = 8'(nw); weight_num = 8'(wn); pixel_num = 8'(pn); col_len = 8'(col);
        pad_data_ready = 1'b1; pad_full = 1'b0; fmap_ready_to_pe = 1'b0; layer_start = 1'b1;
        hist_addr[0] = raddra_ifmap;
        hist_busy[0] = busy;
        for (int cyc = 1; cyc <= MAXC; cyc++) begin
            @(posedge clk); #1;
            layer_start = (cyc == extra_start);
            hist_addr[cyc] = raddra_ifmap;
            hist_busy[cyc] = busy;
            if (fmap_rd_valid) begin
                got_addr.push_back(hist_addr[cyc-1]);
                got_plast.push_back(pass_last);
                rd_cyc.push_back(cyc);
            end
            if (window_done) wdone_cyc.push_back(cyc);
            if (fmap_load_start) begin
                start_cyc.push_back(cyc);
                start_full.push_back(load_full_cloumn);
                if (pend) viol++;
                ready_at = cyc + ready_dly;
            end
            rdy = (cyc == ready_at);
            fmap_ready_to_pe = rdy;
            if (rdy) ready_cyc.push_back(cyc);
            pend = fmap_load_start ? 1'b1 : (rdy ? 1'b0 : pend);
            pad_full = (cyc >= stall_at) && (cyc < stall_at + stall_len);
            if (layer_done) begin
                ldone_cnt++;
                if (ldone_cyc < 0) ldone_cyc = cyc;
            end
            if (ldone_cyc >= 0 && cyc == ldone_cyc + 2) begin
                timed_out = 1'b0;
                break;
            end
        end
        layer_start = 1'b0; pad_full = 1'b0; fmap_ready_to_pe = 1'b0;
    endtask

    task automatic build_expected(input int nw, input int wn, input int pn, input int col);
        exp_addr.delete(); exp_plast.delete();
        for (int w = 0; w < nw; w++)
            for (int p = 0; p < wn; p++)
                for (int i = 0; i < pn; i++) begin
                    exp_addr.push_back(8'((w * col + i) % 256));
                    exp_plast.push_back(i == pn - 1);
                end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({fmap_load_start, load_full_cloumn, raddra_ifmap, fmap_rd_valid, pass_last,
             window_done, layer_done, busy} !== 15'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {fmap_load_start, load_full_cloumn,
                     raddra_ifmap, fmap_rd_valid, pass_last, window_done, layer_done, busy});
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || layer_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle busy=%b layer_done=%b exp=0/0", busy, layer_done);
        end
    endtask

    task automatic test_full_load(input string name, input int extra_start);
        run_layer(1, 2, 4, 0, -1, 0, 3, extra_start);
        build_expected(1, 2, 4, 0);
        checks++;
        if (timed_out) begin errors++; $display("FAIL %s_timeout no layer_done in %0d cycles", name, MAXC); end
        checks++;
        if (start_cyc.size() != 1 || start_full[0] !== 1'b1 || start_cyc[0] != 2) begin
            errors++;
            $display("FAIL %s_start count=%0d exp=1 (full, cycle 2)", name, start_cyc.size());
        end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL %s_rd_count got=%0d exp=%0d", name, got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_plast[i] !== exp_plast[i] || rd_cyc[i] != 4 + i) begin
                errors++;
                $display("FAIL %s_rd[%0d] addr=%h plast=%b cyc=%0d exp addr=%h plast=%b cyc=%0d",
                         name, i, got_addr[i], got_plast[i], rd_cyc[i], exp_addr[i], exp_plast[i], 4 + i);
            end
        end
        checks++;
        if (wdone_cyc.size() != 1 || wdone_cyc[0] != 11) begin
            errors++; $display("FAIL %s_window_done count=%0d exp=1 at cycle 11", name, wdone_cyc.size());
        end
        checks++;
        if (ldone_cyc != 12 || ldone_cnt != 1) begin
            errors++; $display("FAIL %s_layer_done cyc=%0d cnt=%0d exp=12/1", name, ldone_cyc, ldone_cnt);
        end
        checks++;
        if (hist_busy[1] !== 1'b1 || hist_busy[11] !== 1'b1 || hist_busy[12] !== 1'b0 || hist_busy[14] !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy c1=%b c11=%b c12=%b c14=%b exp=1/1/0/0", name,
                     hist_busy[1], hist_busy[11], hist_busy[12], hist_busy[14]);
        end
    endtask

    task automatic test_columns();
        int exp_start[3] = '{2, 10, 18};
        run_layer(3, 1, 4, 2, -1, 0, 5, -1);
        build_expected(3, 1, 4, 2);
        checks++;
        if (timed_out) begin errors++; $display("FAIL col_timeout no layer_done in %0d cycles", MAXC); end
        checks++;
        if (start_cyc.size() != 3) begin
            errors++; $display("FAIL col_start_count got=%0d exp=3", start_cyc.size());
        end
        for (int k = 0; k < 3 && k < start_cyc.size(); k++) begin
            checks++;
            if (start_cyc[k] != exp_start[k] || start_full[k] !== (k == 0)) begin
                errors++;
                $display("FAIL col_start[%0d] cyc=%0d full=%b exp cyc=%0d full=%b",
                         k, start_cyc[k], start_full[k], exp_start[k], k == 0);
            end
            if (k > 0 && ready_cyc.size() >= k) begin
                checks++;
                if (start_cyc[k] <= ready_cyc[k-1]) begin
                    errors++;
                    $display("FAIL col_start_before_ready start=%0d ready=%0d", start_cyc[k], ready_cyc[k-1]);
                end
            end
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL col_start_while_pending got=%0d exp=0", viol); end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            errors++; $display("FAIL col_rd_count got=%0d exp=%0d", got_addr.size(), exp_addr.size());
        end
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_plast[i] !== exp_plast[i]) begin
                errors++;
                $display("FAIL col_rd[%0d] addr=%h plast=%b exp addr=%h plast=%b",
                         i, got_addr[i], got_plast[i], exp_addr[i], exp_plast[i]);
            end
        end
        checks++;
        if (wdone_cyc.size() != 3 || wdone_cyc[0] != 7 || wdone_cyc[1] != 15 || wdone_cyc[2] != 23) begin
            errors++; $display("FAIL col_window_done count=%0d exp=3 at 7/15/23", wdone_cyc.size());
        end
        checks++;
        if (ldone_cyc != 24) begin errors++; $display("FAIL col_layer_done cyc=%0d exp=24", ldone_cyc); end
    endtask

    task automatic test_stall();
        int exp_rd[8] = '{4, 5, 9, 10, 11, 12, 13, 14};
        run_layer(1, 1, 8, 0, 4, 3, 3, -1);
        build_expected(1, 1, 8, 0);
        checks++;
        if (timed_out) begin errors++; $display("FAIL stall_timeout no layer_done in %0d cycles", MAXC); end
        checks++;
        if (got_addr.size() != 8) begin errors++; $display("FAIL stall_rd_count got=%0d exp=8", got_addr.size()); end
        for (int i = 0; i < 8 && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || rd_cyc[i] != exp_rd[i]) begin
                errors++;
                $display("FAIL stall_rd[%0d] addr=%h cyc=%0d exp addr=%h cyc=%0d",
                         i, got_addr[i], rd_cyc[i], exp_addr[i], exp_rd[i]);
            end
        end
        checks++;
        if (hist_addr[5] !== 8'h01 || hist_addr[6] !== 8'h01 || hist_addr[7] !== 8'h01 || hist_addr[8] !== 8'h02) begin
            errors++;
            $display("FAIL stall_addr_hold c5=%h c6=%h c7=%h c8=%h exp=01/01/01/02",
                     hist_addr[5], hist_addr[6], hist_addr[7], hist_addr[8]);
        end
        checks++;
        if (ldone_cyc != 15) begin errors++; $display("FAIL stall_layer_done cyc=%0d exp=15", ldone_cyc); end
    endtask

    task automatic test_wrap();
        run_layer(3, 1, 4, 8'h80, -1, 0, 2, -1);
        build_expected(3, 1, 4, 8'h80);
        checks++;
        if (timed_out) begin errors++; $display("FAIL wrap_timeout no layer_done in %0d cycles", MAXC); end
        checks++;
        if (got_addr.size() != 12) begin errors++; $display("FAIL wrap_rd_count got=%0d exp=12", got_addr.size()); end
        for (int i = 0; i < 12 && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i]) begin
                errors++; $display("FAIL wrap_rd[%0d] addr=%h exp=%h", i, got_addr[i], exp_addr[i]);
            end
        end
    endtask

    task automatic test_degenerate();
        run_layer(2, 0, 4, 1, -1, 0, 3, -1);
        checks++;
        if (ldone_cyc != 2 || start_cyc.size() != 0 || rd_cyc.size() != 0 || wdone_cyc.size() != 0) begin
            errors++;
            $display("FAIL degen_wn0 ldone=%0d starts=%0d rds=%0d wdone=%0d exp=2/0/0/0",
                     ldone_cyc, start_cyc.size(), rd_cyc.size(), wdone_cyc.size());
        end
        run_layer(2, 3, 0, 1, -1, 0, 3, -1);
        checks++;
        if (ldone_cyc != 2 || start_cyc.size() != 0 || rd_cyc.size() != 0) begin
            errors++;
            $display("FAIL degen_pn0 ldone=%0d starts=%0d rds=%0d exp=2/0/0", ldone_cyc, start_cyc.size(), rd_cyc.size());
        end
    endtask

    task automatic test_abort();
        bit seen;
        num_windows = 8'd1; weight_num = 8'd2; pixel_num = 8'd4; col_len = 8'd0;
        pad_data_ready = 1'b1; pad_full = 1'b0; layer_start = 1'b1;
        @(posedge clk); #1;
        layer_start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || fmap_rd_valid !== 1'b1) begin
            errors++; $display("FAIL abort_mid_read busy=%b rd_valid=%b exp=1/1", busy, fmap_rd_valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({fmap_load_start, load_full_cloumn, raddra_ifmap, fmap_rd_valid, pass_last,
             window_done, layer_done, busy} !== 15'h0) begin
            errors++;
            $display("FAIL abort_outputs raddr=%h busy=%b rd_valid=%b exp all 0", raddra_ifmap, busy, fmap_rd_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (layer_done || window_done || fmap_rd_valid || busy || fmap_load_start) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL abort_no_completion got activity=1 exp=0"); end
        test_full_load("after_abort", -1);
    endtask

    initial begin
        test_reset();
        test_full_load("full", -1);
        test_columns();
        test_stall();
        test_wrap();
        test_degenerate();
        test_full_load("busy_ignore", 6);
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
